// File: rtl/transposer_row_feeder_if.sv
// Row stream into the feeder and tile-framed row stream out to the transposer.
// The slave modport is the feeder's view; the master modport is the producer/consumer side.
interface transposer_row_feeder_if #(
    parameter int DIM = 16,
    parameter int W   = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [DIM*W-1:0]   in_row;
    logic               in_last;
    logic               out_row_valid;
    logic [DIM*W-1:0]   out_row;
    logic               out_tile_first;
    logic               out_tile_last;
    logic               busy;

    modport master (
        output in_valid, in_row, in_last,
        input  in_ready, out_row_valid, out_row, out_tile_first, out_tile_last, busy
    );

    modport slave (
        input  in_valid, in_row, in_last,
        output in_ready, out_row_valid, out_row, out_tile_first, out_tile_last, busy
    );
endinterface

// File: rtl/transposer_row_feeder.sv
// Buffers incoming rows in a FIFO and issues each tile as DIM back-to-back valid rows,
// zero-padding tiles closed early by in_last.
module transposer_row_feeder #(
    parameter int DIM   = 16,
    parameter int W     = 8,
    parameter int DEPTH = 2 * DIM
) (
    input  logic                   clk,
    input  logic                   rst,
    transposer_row_feeder_if.slave bus
);
    localparam int RW    = DIM * W;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [OCC_W-1:0] DIM_OCC   = OCC_W'(DIM);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIM - 1);

    generate
        if (DEPTH < DIM) begin : g_depth_check
            $error("transposer_row_feeder: DEPTH must be >= DIM");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, FEED, PAD} state_t;

    logic [RW:0]      mem_q [DEPTH];
    logic [RW:0]      head;
    logic             push;
    logic             pop;
    logic             tile_end;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] lasts_q, lasts_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [RW-1:0]    out_row_q, out_row_d;
    logic             out_first_q, out_first_d;
    logic             out_last_q, out_last_d;

    assign push = bus.in_valid & in_ready_q;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        pop         = 1'b0;
        tile_end    = 1'b0;
        out_valid_d = 1'b0;
        out_row_d   = '0;
        case (state_q)
            IDLE: begin
                // Either a full tile is buffered or a closing row is, so FEED never underruns.
                if ((occ_q >= DIM_OCC) || (lasts_q != '0)) state_d = FEED;
            end
            FEED: begin
                pop         = 1'b1;
                out_valid_d = 1'b1;
                out_row_d   = head[RW-1:0];
                if (row_cnt_q == CNT_LAST) begin
                    tile_end = 1'b1;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                    if (head[RW]) state_d = PAD;
                end
            end
            PAD: begin
                out_valid_d = 1'b1;
                if (row_cnt_q == CNT_LAST) tile_end = 1'b1;
                else row_cnt_d = row_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        out_first_d = out_valid_d && (row_cnt_q == '0);
        out_last_d  = out_valid_d && (row_cnt_q == CNT_LAST);

        occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
        lasts_d  = lasts_q + OCC_W'(push & bus.in_last) - OCC_W'(pop & head[RW]);
        wr_ptr_d = push ? ((wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop  ? ((rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        in_ready_d = (occ_d < DEPTH_OCC);

        // Re-test the start condition on next-cycle counts so consecutive tiles run gap-free.
        if (tile_end) begin
            row_cnt_d = '0;
            state_d   = ((occ_d >= DIM_OCC) || (lasts_d != '0)) ? FEED : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            occ_q       <= '0;
            lasts_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            occ_q       <= occ_d;
            lasts_q     <= lasts_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.in_last, bus.in_row};
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_row_valid  = out_valid_q;
    assign bus.out_row        = out_row_q;
    assign bus.out_tile_first = out_first_q;
    assign bus.out_tile_last  = out_last_q;
    assign bus.busy           = (occ_q != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_transposer_row_feeder.sv
// Directed bench for transposer_row_feeder: a tile-level reference model plus a
// small shallow-FIFO instance to exercise backpressure.
module tb_transposer_row_feeder;
    localparam int DIM  = 16;
    localparam int W    = 8;
    localparam int RW   = DIM * W;
    localparam int DIM2 = 4;
    localparam int RW2  = DIM2 * W;

    typedef logic [135:0] wide_t;
    typedef struct {
        logic [RW-1:0] row;
        logic          first;
        logic          last;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    transposer_row_feeder_if #(.DIM(DIM),  .W(W)) bus0 ();
    transposer_row_feeder_if #(.DIM(DIM2), .W(W)) bus1 ();

    transposer_row_feeder #(.DIM(DIM), .W(W), .DEPTH(2 * DIM)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    transposer_row_feeder #(.DIM(DIM2), .W(W), .DEPTH(DIM2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [RW-1:0]  pending[$];
    obs_t           exp_q[$];
    obs_t           log0[$];
    logic [RW2-1:0] sb2[$];
    int  run_len = 0, max_run = 0;
    bit  ready_dropped = 1'b0;
    int  out2_cnt = 0, push2_cnt = 0, push2_at_drop = -1;
    bit  drop2_seen = 1'b0;

    task automatic check(input string name, input wide_t got, input wide_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [RW-1:0] mk_row(input int v);
        logic [RW-1:0] r;
        for (int i = 0; i < DIM; i++) r[i*W +: W] = W'(v);
        return r;
    endfunction

    function automatic logic [RW2-1:0] mk_row2(input int v);
        logic [RW2-1:0] r;
        for (int i = 0; i < DIM2; i++) r[i*W +: W] = W'(v);
        return r;
    endfunction

    function automatic wide_t pk(input obs_t o);
        return {o.first, o.last, o.row};
    endfunction

    // Reference: a tile is the pending rows up to a last or DIM rows, zero-filled to DIM.
    task automatic model_push(input logic [RW-1:0] r, input logic l);
        obs_t e;
        pending.push_back(r);
        if (l || pending.size() == DIM) begin
            for (int k = 0; k < DIM; k++) begin
                e.row   = (k < pending.size()) ? pending[k] : '0;
                e.first = (k == 0);
                e.last  = (k == DIM - 1);
                exp_q.push_back(e);
            end
            pending.delete();
        end
    endtask

    always @(negedge clk) begin
        obs_t  o, e;
        wide_t expw;
        logic  gap;
        if (rst) begin
            pending.delete();
            exp_q.delete();
            sb2.delete();
            run_len  = 0;
            out2_cnt = 0;
            check("reset_outputs0", {bus0.out_row_valid, bus0.out_tile_first, bus0.out_tile_last,
                                     bus0.in_ready, bus0.busy, bus0.out_row}, '0);
            check("reset_outputs1", {bus1.out_row_valid, bus1.out_tile_first, bus1.out_tile_last,
                                     bus1.in_ready, bus1.busy, bus1.out_row}, '0);
        end else begin
            if (bus0.out_row_valid) begin
                o.row = bus0.out_row; o.first = bus0.out_tile_first; o.last = bus0.out_tile_last;
                log0.push_back(o);
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    expw = pk(e);
                end else begin
                    expw = {1'b1, 2'b00, {RW{1'b0}}};
                end
                check("out_row", pk(o), expw);
            end else begin
                run_len = 0;
                gap = (exp_q.size() > 0) && !exp_q[0].first;
                check("idle_out", {gap, bus0.out_tile_first, bus0.out_tile_last, bus0.out_row}, '0);
            end
            if (!bus0.in_ready) ready_dropped = 1'b1;
            if (bus0.in_valid && bus0.in_ready) model_push(bus0.in_row, bus0.in_last);

            if (bus1.out_row_valid) begin
                expw = (sb2.size() > 0) ? wide_t'(sb2.pop_front()) : {1'b1, {RW2{1'b0}}};
                check("out2_row", wide_t'(bus1.out_row), expw);
                check("out2_flags", {bus1.out_tile_first, bus1.out_tile_last},
                      {(out2_cnt % DIM2) == 0, (out2_cnt % DIM2) == DIM2 - 1});
                out2_cnt++;
            end else begin
                check("idle_out2", {bus1.out_tile_first, bus1.out_tile_last, bus1.out_row}, '0);
            end
            if (!bus1.in_ready && !drop2_seen) begin
                drop2_seen    = 1'b1;
                push2_at_drop = push2_cnt;
            end
            if (bus1.in_valid && bus1.in_ready) begin
                sb2.push_back(bus1.in_row);
                push2_cnt++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the row is accepted.
    task automatic send0(input logic [RW-1:0] r, input logic l);
        int g = 0;
        bus0.in_valid = 1'b1; bus0.in_row = r; bus0.in_last = l;
        do begin @(negedge clk); g++; end while (!bus0.in_ready && g < 200);
        check("send0_timeout", wide_t'(g >= 200), '0);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0; bus0.in_row = '0; bus0.in_last = 1'b0;
    endtask

    task automatic send1(input logic [RW2-1:0] r);
        int g = 0;
        bus1.in_valid = 1'b1; bus1.in_row = r; bus1.in_last = 1'b0;
        do begin @(negedge clk); g++; end while (!bus1.in_ready && g < 200);
        check("send1_timeout", wide_t'(g >= 200), '0);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0; bus1.in_row = '0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || sb2.size() != 0 || bus0.busy || bus1.busy) && g < 1000) begin
            @(negedge clk); g++;
        end
        check("drain_timeout", wide_t'(g >= 1000), '0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        bus0.in_valid = 1'b0; bus0.in_row = '0; bus0.in_last = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_row = '0; bus1.in_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", {bus0.out_row_valid, bus0.in_ready, bus0.busy}, '0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_before_first_clk", wide_t'(bus0.in_ready), '0);
        @(negedge clk);
        check("ready_after_first_clk", wide_t'(bus0.in_ready), 1);
        @(posedge clk); #1;

        // Full tile closed by a last on row 15.
        log0.delete();
        for (int k = 0; k < DIM; k++) send0(mk_row(k), k == DIM - 1);
        wait_drain();
        check("t1_rows", log0.size(), 16);
        check("t1_row0", pk(log0[0]), {1'b1, 1'b0, mk_row(0)});
        check("t1_row15", pk(log0[15]), {1'b0, 1'b1, mk_row(15)});
        check("t1_run", max_run, 16);

        // Short tile of 5 rows padded to 16.
        log0.delete();
        for (int k = 0; k < 5; k++) send0(mk_row(100 + k), k == 4);
        wait_drain();
        check("t2_rows", log0.size(), 16);
        check("t2_row4", pk(log0[4]), {1'b0, 1'b0, mk_row(104)});
        check("t2_row5_pad", pk(log0[5]), '0);
        check("t2_row15_pad", pk(log0[15]), {1'b0, 1'b1, {RW{1'b0}}});

        // Continuous 64-row stream without last.
        log0.delete(); max_run = 0; ready_dropped = 1'b0;
        for (int k = 0; k < 64; k++) send0(mk_row(k), 1'b0);
        wait_drain();
        check("t3_rows", log0.size(), 64);
        check("t3_run", max_run, 64);
        check("t3_ready_dropped", wide_t'(ready_dropped), '0);
        check("t3_row48", pk(log0[48]), {1'b1, 1'b0, mk_row(48)});
        check("t3_row63", pk(log0[63]), {1'b0, 1'b1, mk_row(63)});

        // Shallow FIFO: backpressure at full occupancy, nothing lost or duplicated.
        drop2_seen = 1'b0; push2_cnt = 0; out2_cnt = 0;
        for (int k = 0; k < 12; k++) send1(mk_row2(k + 1));
        wait_drain();
        check("t4_drop_seen", wide_t'(drop2_seen), 1);
        check("t4_pushes_at_full", push2_at_drop, 4);
        check("t4_rows_out", out2_cnt, 12);

        // Reset while row 7 of a tile is on the output.
        log0.delete();
        for (int k = 0; k < DIM; k++) send0(mk_row(k), 1'b0);
        g = 0;
        do begin @(negedge clk); g++; end
        while (!(bus0.out_row_valid && bus0.out_row == mk_row(7)) && g < 200);
        check("t5_row7_timeout", wide_t'(g >= 200), '0);
        #3 rst = 1'b1;
        #1 check("t5_rst_outputs", {bus0.out_row_valid, bus0.out_tile_first, bus0.out_tile_last,
                                    bus0.busy, bus0.out_row}, '0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        log0.delete();
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) send0(mk_row(50 + k), k == 2);
        wait_drain();
        check("t5_rows", log0.size(), 16);
        check("t5_row0", pk(log0[0]), {1'b1, 1'b0, mk_row(50)});
        check("t5_row2", pk(log0[2]), {1'b0, 1'b0, mk_row(52)});
        check("t5_row3_pad", pk(log0[3]), '0);

        // 15 rows without last must wait; the 16th starts the tile.
        log0.delete();
        for (int k = 0; k < 15; k++) send0(mk_row(200 + k), 1'b0);
        repeat (100) @(negedge clk);
        check("t6_no_rows", log0.size(), 0);
        check("t6_busy", {bus0.busy, bus0.out_row_valid}, 2'b10);
        @(posedge clk); #1;
        send0(mk_row(215), 1'b0);
        wait_drain();
        check("t6_rows", log0.size(), 16);
        check("t6_row0", pk(log0[0]), {1'b1, 1'b0, mk_row(200)});
        check("t6_row15", pk(log0[15]), {1'b0, 1'b1, mk_row(215)});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
